// File: rtl/axi_lite_master_pkg.sv
// rtl/axi_lite_master_pkg.sv - shared widths, response codes and FSM states for the AXI4-lite master
package axi_lite_master_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP
  } state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_lite_master_if.sv
// rtl/axi_lite_master_if.sv - request/response port plus AXI4-lite channels of the master
interface axi_lite_master_if
  import axi_lite_master_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [STRB_WIDTH-1:0] req_wstrb;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  AWVALID;
  logic                  AWREADY;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [2:0]            AWPROT;
  logic                  WVALID;
  logic                  WREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  BVALID;
  logic                  BREADY;
  logic [1:0]            BRESP;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [2:0]            ARPROT;
  logic                  RVALID;
  logic                  RREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output AWVALID, AWADDR, AWPROT, input AWREADY,
    output WVALID, WDATA, WSTRB, input WREADY,
    input  BVALID, BRESP, output BREADY,
    output ARVALID, ARADDR, ARPROT, input ARREADY,
    input  RVALID, RDATA, RRESP, output RREADY
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  AWVALID, AWADDR, AWPROT, output AWREADY,
    input  WVALID, WDATA, WSTRB, output WREADY,
    output BVALID, BRESP, input BREADY,
    input  ARVALID, ARADDR, ARPROT, output ARREADY,
    output RVALID, RDATA, RRESP, input RREADY
  );

endinterface

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI4-lite initiator with one-cycle response pulse
module axi_lite_master
  import axi_lite_master_pkg::*;
#(
  parameter int         ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int         DATA_WIDTH = AXI_DATA_WIDTH,
  parameter logic [2:0] PROT       = 3'b000
) (
  input logic               ACLK,
  input logic               ARESET,
  axi_lite_master_if.master bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t                state_q, state_d;
  logic                  aw_valid_q, aw_valid_d;
  logic                  w_valid_q, w_valid_d;
  logic                  ar_valid_q, ar_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  aw_done, w_done;

  // A channel counts as done once its VALID has dropped or is handshaking now.
  assign aw_done = !aw_valid_q || bus.AWREADY;
  assign w_done  = !w_valid_q || bus.WREADY;

  always_comb begin
    state_d     = state_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    ar_valid_d  = ar_valid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d = bus.req_addr;
          if (bus.req_write) begin
            wdata_d    = bus.req_wdata;
            wstrb_d    = bus.req_wstrb;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            state_d    = ST_WR_REQ;
          end else begin
            ar_valid_d = 1'b1;
            state_d    = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        if (aw_valid_q && bus.AWREADY) aw_valid_d = 1'b0;
        if (w_valid_q && bus.WREADY)   w_valid_d  = 1'b0;
        if (aw_done && w_done)         state_d    = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (bus.BVALID) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = resp_is_err(bus.BRESP);
          rsp_rdata_d = '0;
          state_d     = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        // RREADY is already high here, so a slave answering with ARREADY+RVALID completes at once.
        if (bus.ARREADY) begin
          ar_valid_d = 1'b0;
          if (bus.RVALID) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = resp_is_err(bus.RRESP);
            rsp_rdata_d = bus.RDATA;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_RD_RESP;
          end
        end
      end
      ST_RD_RESP: begin
        if (bus.RVALID) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = resp_is_err(bus.RRESP);
          rsp_rdata_d = bus.RDATA;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      ar_valid_q  <= ar_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign bus.AWVALID = aw_valid_q;
  assign bus.AWADDR  = addr_q;
  assign bus.AWPROT  = PROT;
  assign bus.WVALID  = w_valid_q;
  assign bus.WDATA   = wdata_q;
  assign bus.WSTRB   = wstrb_q;
  assign bus.BREADY  = (state_q == ST_WR_RESP);
  assign bus.ARVALID = ar_valid_q;
  assign bus.ARADDR  = addr_q;
  assign bus.ARPROT  = PROT;
  assign bus.RREADY  = (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- AXI4-lite initiator (master) bridging a simple single-request core/DMA port onto the AXI4-lite fabric; the counterpart of the team's AXI4-lite slave adapter.
- One transaction outstanding at a time, read or write, with a single-cycle response pulse back to the requester.
- Sits between a bus-master IP (CPU LSU, debug module) and the AXI4-lite interconnect/slave.

Parameters:
- ADDR_WIDTH, 32, address width (matches `AXI_ADDR_WIDTH).
- DATA_WIDTH, 32, data width (matches `AXI_DATA_WIDTH); STRB_WIDTH = DATA_WIDTH/8, derived.
- PROT, 3'b000, constant value driven on AWPROT/ARPROT.

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wstrb  in  STRB_WIDTH  write byte strobes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid on reads; 0 on writes.
- rsp_err  out  1  1 when RRESP/BRESP[1] set (SLVERR/DECERR).
- AWVALID out 1; AWREADY in 1; AWADDR out ADDR_WIDTH; AWPROT out 3.
- WVALID out 1; WREADY in 1; WDATA out DATA_WIDTH; WSTRB out STRB_WIDTH.
- BVALID in 1; BREADY out 1; BRESP in 2.
- ARVALID out 1; ARREADY in 1; ARADDR out ADDR_WIDTH; ARPROT out 3.
- RVALID in 1; RREADY out 1; RDATA in DATA_WIDTH; RRESP in 2.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - All VALID/READY outputs 0; rsp_valid 0; rsp_rdata 0; rsp_err 0.
  - AWADDR/ARADDR/WDATA/WSTRB 0.
  - Reset mid-transaction abandons it and produces no rsp_valid.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- req_ready = (state == IDLE), combinational from state only. The block never depends on req_valid for its ready.
- IDLE, on accept (cycle 0):
  - Register addr/data/strb into AW/W/AR outputs.
  - Write: go to WR_REQ with AWVALID = WVALID = 1 from cycle 1.
  - Read: go to RD_REQ with ARVALID = 1 from cycle 1.
- WR_REQ:
  - AWVALID drops the cycle after AWVALID & AWREADY; WVALID drops the cycle after WVALID & WREADY. The two handshakes are tracked independently (aw_done, w_done flags), in either order or the same cycle.
  - When both are complete, go to WR_RESP. With always-ready slaves, both handshakes occur in cycle 1 and the block is in WR_RESP at cycle 2.
  - AW/W payloads stay stable while their VALID is high.
- WR_RESP:
  - BREADY = 1.
  - On BVALID: next cycle rsp_valid = 1, rsp_err = BRESP[1], rsp_rdata = 0; state returns to IDLE.
- RD_REQ:
  - ARVALID held until ARREADY.
  - RREADY = 1 already in RD_REQ, to tolerate slaves that assert ARREADY together with RVALID.
  - If RVALID is seen in the same cycle as the AR handshake, complete directly; otherwise go to RD_RESP.
- RD_RESP:
  - RREADY = 1.
  - On RVALID: capture RDATA, set rsp_err = RRESP[1], pulse rsp_valid next cycle, return to IDLE.
- rsp_valid:
  - High exactly one cycle per transaction.
  - rsp_rdata/rsp_err hold their last value until the next completion.
  - req_ready is high in the same cycle as rsp_valid, so back-to-back requests are allowed.
- Invariants:
  - Never more than one VALID class active: AW/W and AR are mutually exclusive.
  - No VALID is deasserted before its handshake.
  - BVALID/RVALID arriving in an unexpected state are ignored (READY low).

Decomposition:
- Shared header axi_defines.vh provides `AXI_ADDR_WIDTH, `AXI_DATA_WIDTH, `AXI_STRB_WIDTH, and response codes `OKAY/`EXOKAY/`SLVERR/`DECERR.
- The state encodings for this block are added to the same header.
- No sub-module: single FSM plus output registers, about 200 lines.

Test Plan:
- Write, always-ready slave, addr 0x1000_0010, data 0xDEADBEEF, strb 4'hF:
  - AW/W valid in cycle 1, BREADY in cycle 2.
  - BVALID with BRESP=OKAY in cycle 3 → rsp_valid in cycle 4, rsp_err=0.
- Write, AWREADY delayed 3 cycles while WREADY is immediate:
  - WVALID drops after 1 cycle; AWVALID held with AWADDR stable.
  - WR_RESP is entered only after the AW handshake.
  - BRESP=2'b10 → rsp_err=1.
- Read, slave asserts ARREADY and RVALID together in cycle 4 with RDATA=0x12345678:
  - ARVALID held cycles 1–4; RREADY high.
  - rsp_valid in cycle 5, rsp_rdata=0x12345678, rsp_err=0.
- Read, ARREADY in cycle 1 and RVALID in cycle 6 with RRESP=DECERR:
  - RD_RESP entered at cycle 2.
  - rsp_valid at cycle 7 with rsp_err=1.
- Back-to-back traffic, read at the rsp_valid cycle of a preceding write:
  - Read accepted the same cycle; no AW/AR overlap; exactly one rsp_valid per request.
- ARESET asserted while in WR_REQ with AWVALID=1:
  - All VALIDs drop immediately with no rsp_valid.
  - After release, req_ready=1 and a new read completes normally.
